// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Two-channel switch conditioner. Each raw switch input is
//               brought into the clk domain by a two-flop synchronizer. A
//               two-state FSM with a saturating stability counter then
//               filters contact bounce. Outputs are clean levels A/B plus
//               registered single-cycle rise/fall strobes per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic SW_A,
  input  logic SW_B,
  output logic A,
  output logic B,
  output logic A_RISE,
  output logic A_FALL,
  output logic B_RISE,
  output logic B_FALL
);

  localparam logic [0:0]       c_ST_STABLE   = 1'b0;
  localparam logic [0:0]       c_ST_COUNTING = 1'b1;
  localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] w_sw;
  logic [1:0] w_lvl;
  logic [1:0] w_rise;
  logic [1:0] w_fall;

  // Channel 0 is A, channel 1 is B; both run the identical filter below.
  assign w_sw = {SW_B, SW_A};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic             r_s1;
    logic             r_s2;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;

    // Two-flop synchronizer; r_s2 is the only view of the switch used below.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_sw[gi];
        r_s2 <= r_s1;
      end
    end

    // Debounce FSM: the output flips only after DEBOUNCE_CYCLES consecutive
    // mismatching samples; any bounce back discards the partial count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= c_ST_STABLE;
        r_cnt   <= '0;
        r_out   <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        case (r_state)
          c_ST_STABLE: begin
            if (r_s2 != r_out) begin
              r_state <= c_ST_COUNTING;
              r_cnt   <= c_CNT_ONE;
            end
          end
          c_ST_COUNTING: begin
            if (r_s2 == r_out) begin
              r_state <= c_ST_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
              // Strobes are registered alongside the level so they appear
              // in the same cycle the new level does.
              r_out   <= ~r_out;
              r_rise  <= ~r_out;
              r_fall  <= r_out;
              r_state <= c_ST_STABLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          default: begin
            r_state <= c_ST_STABLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_lvl[gi]  = r_out;
    assign w_rise[gi] = r_rise;
    assign w_fall[gi] = r_fall;
  end

  assign A      = w_lvl[0];
  assign B      = w_lvl[1];
  assign A_RISE = w_rise[0];
  assign A_FALL = w_fall[0];
  assign B_RISE = w_rise[1];
  assign B_FALL = w_fall[1];

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Self-checking bench for switch_debouncer with a short
//               debounce window. Directed vector table, hand-written corner
//               sequences and randomized stimulus against a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

  localparam int D = 4;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SW_A = 1'b0;
  logic SW_B = 1'b0;
  logic A, B, A_RISE, A_FALL, B_RISE, B_FALL;

  int n_vec = 0;
  int n_bad = 0;

  switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .SW_A(SW_A), .SW_B(SW_B),
    .A(A), .B(B), .A_RISE(A_RISE), .A_FALL(A_FALL),
    .B_RISE(B_RISE), .B_FALL(B_FALL)
  );

  always #5 clk = ~clk;

  // Reference model: the raw input is delayed two edges, and an output
  // flips once the last D delayed samples since its previous flip all
  // disagree with it.
  logic m_d1 [2];
  logic m_d2 [2];
  logic m_out [2];
  logic m_rise [2];
  logic m_fall [2];
  logic m_win [2][$];

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_d1[ch] = 1'b0; m_d2[ch] = 1'b0; m_out[ch] = 1'b0;
      m_rise[ch] = 1'b0; m_fall[ch] = 1'b0;
      m_win[ch].delete();
    end
  endtask

  task automatic model_edge(input logic sa, input logic sb);
    logic raw [2];
    raw[0] = sa;
    raw[1] = sb;
    for (int ch = 0; ch < 2; ch++) begin
      bit all_diff;
      m_win[ch].push_back(m_d2[ch]);
      if (m_win[ch].size() > D) void'(m_win[ch].pop_front());
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      all_diff = (m_win[ch].size() == D);
      for (int k = 0; k < m_win[ch].size(); k++)
        if (m_win[ch][k] == m_out[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_rise[ch] = ~m_out[ch];
        m_fall[ch] = m_out[ch];
        m_out[ch]  = ~m_out[ch];
        m_win[ch].delete();
      end
      m_d2[ch] = m_d1[ch];
      m_d1[ch] = raw[ch];
    end
  endtask

  function automatic logic [5:0] dut_vec();
    return {A, B, A_RISE, A_FALL, B_RISE, B_FALL};
  endfunction

  function automatic logic [5:0] model_vec();
    return {m_out[0], m_out[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 ns later.
  task automatic cycle(input logic sa, input logic sb, output logic [5:0] act);
    SW_A = sa;
    SW_B = sb;
    @(posedge clk);
    model_edge(sa, sb);
    #1;
    act = dut_vec();
  endtask

  // Asynchronous reset pulse placed mid-cycle, with no clock edge inside it.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_async_zero", int'(dut_vec()), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       sa;
    logic       sb;
    logic [5:0] exp;   // {A, B, A_RISE, A_FALL, B_RISE, B_FALL}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic sa, input logic sb, input logic [5:0] e, input int n);
    vec_t v;
    v.sa = sa; v.sb = sb; v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] act;
    int first_rise, rise_cnt, hold;
    logic ra, rb;

    // Clean press/release on A, short glitch on B, then simultaneous
    // opposite-direction changes on both channels.
    add(1, 1, 6'b000000, 3);
    add(1, 0, 6'b000000, 2);
    add(1, 0, 6'b101000, 1);
    add(1, 0, 6'b100000, 1);
    add(0, 0, 6'b100000, 5);
    add(0, 0, 6'b000100, 1);
    add(0, 0, 6'b000000, 1);
    add(0, 1, 6'b000000, 5);
    add(0, 1, 6'b010010, 1);
    add(0, 1, 6'b010000, 1);
    add(1, 0, 6'b010000, 5);
    add(1, 0, 6'b101001, 1);
    add(1, 0, 6'b100000, 1);

    model_reset();
    #12;
    check("reset_state", int'(dut_vec()), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].sa, tbl[i].sb, act);
      check($sformatf("table[%0d]", i), int'(act), int'(tbl[i].exp));
    end

    // Reset mid-count: both switches high for 3 edges, reset, then the full
    // 2+D latency must elapse again.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, act);
      check("pre_idle", int'(act), int'(model_vec()));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, act);
      check("midcount", int'(act), int'(model_vec()));
    end
    do_reset();
    first_rise = -1;
    rise_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 1, act);
      check("post_reset", int'(act), int'(model_vec()));
      if (A_RISE) rise_cnt++;
      if (A && first_rise < 0) first_rise = i;
    end
    check("post_reset_rise_edge", first_rise, 6);
    check("post_reset_rise_pulses", rise_cnt, 1);

    // Bounce on A: alternate for 8 edges then hold high. s2 settles at
    // edge 10, so A must rise at edge 14.
    do_reset();
    first_rise = -1;
    rise_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle((i > 8) ? 1'b1 : logic'(i % 2), 1'b0, act);
      check("bounce", int'(act), int'(model_vec()));
      if (A_RISE) rise_cnt++;
      if (A && first_rise < 0) first_rise = i;
    end
    check("bounce_rise_edge", first_rise, 14);
    check("bounce_rise_pulses", rise_cnt, 1);

    // Randomized: inputs held for random lengths, occasional async reset.
    hold = 0;
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        ra = logic'($urandom_range(1, 0));
        rb = logic'($urandom_range(1, 0));
        hold = int'($urandom_range(7, 1));
      end
      hold--;
      if ($urandom_range(199, 0) == 0) do_reset();
      cycle(ra, rb, act);
      check("random", int'(act), int'(model_vec()));
      if ((A_RISE && A_FALL) || (B_RISE && B_FALL)) begin
        n_bad++;
        $display("FAIL strobe_exclusive: rise and fall both high at t=%0t", $time);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_debouncer.md
# switch_debouncer

Two-channel input conditioner between the board's raw slide switches/pushbuttons and the combinational gate-logic stage. It synchronizes each asynchronous switch input into the `clk` domain and filters contact bounce. It then presents clean levels on `A`/`B`, which the gate stage consumes directly as its `A`/`B` operands. It also emits single-cycle rise/fall strobes per channel for downstream counters or display logic.

## Interface

- `DEBOUNCE_CYCLES`, 500000, number of consecutive cycles a synchronized input must differ from the current output before the output flips (10 ms at 50 MHz); legal range 2..2^CNT_W−1
- `CNT_W`, 19, width of each per-channel stability counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:

- `clk` in 1: single system clock, rising-edge
- `rst` in 1: asynchronous, active-high reset; one clock, reset is asynchronous and active-high
- `SW_A` in 1: raw switch input, channel A, asynchronous to `clk`
- `SW_B` in 1: raw switch input, channel B, asynchronous to `clk`
- `A` out 1: debounced level, channel A
- `B` out 1: debounced level, channel B
- `A_RISE` out 1: one-cycle strobe when `A` goes 0→1
- `A_FALL` out 1: one-cycle strobe when `A` goes 1→0
- `B_RISE` out 1: one-cycle strobe when `B` goes 0→1
- `B_FALL` out 1: one-cycle strobe when `B` goes 1→0

## Operation

- The two channels are identical and fully independent; no shared state.
- Synchronizer: two flops per channel (`s1`, `s2`); `s2` is the only sampled version of the input used anywhere.
- Per-channel FSM with two states:
  - STABLE: `s2 == out`; counter held at 0. If `s2 != out`, go to COUNTING with counter = 1.
  - COUNTING: if `s2 == out` (bounce back), return to STABLE and clear the counter to 0. Otherwise increment the counter. When the counter equals `DEBOUNCE_CYCLES−1` and `s2 != out` still holds, toggle `out` on that edge, return to STABLE and clear the counter to 0.
- The counter never exceeds `DEBOUNCE_CYCLES−1` and never wraps.
- Strobes are registered and asserted in the same cycle `out` first shows its new value. `RISE` and `FALL` are never high together, and strobes last exactly one cycle.
- Asynchronous `rst` at any time, including mid-count, clears both sync flops, counter, state (STABLE), `A`, `B` and all four strobes to 0. A pending partial count is discarded.
- After `rst` deasserts with the switch held high, the output follows only after the full synchronizer and debounce latency. There is no fast path.

## Timing

- Reset values: `A`=0, `B`=0, `A_RISE`=`A_FALL`=`B_RISE`=`B_FALL`=0.
- Latency: a raw input change sampled at edge N reaches `s2` at edge N+1. The output and strobe change at edge N+1+`DEBOUNCE_CYCLES`, provided `s2` stays constant throughout. This is 2+`DEBOUNCE_CYCLES`−1 edges after the first capture; the bench measures it as `DEBOUNCE_CYCLES`+2 cycles ±1 for input phase.
- Any glitch lasting fewer than `DEBOUNCE_CYCLES` consecutive `s2` cycles produces no output change and no strobe.
- Outputs are all registered; no combinational path from `SW_*` to any output.

## Test plan

With `DEBOUNCE_CYCLES`=4 and `CNT_W`=3 for simulation:

- Reset: assert `rst` asynchronously mid-cycle with `SW_A`=`SW_B`=1 and counters mid-count. All outputs are 0 immediately. After release, holding `SW_A`=1 gives `A`=1 and `A_RISE`=1 for one cycle exactly 6 edges after release (2 sync + 4).
- Clean press: `SW_A` 0→1 held steady. `A` rises once, `A_RISE` is high for exactly 1 cycle, `A_FALL` stays 0. Release gives `A` falling and `A_FALL` for exactly 1 cycle.
- Bounce: `SW_A` toggles 1,0,1,0 each cycle for 8 cycles, then holds 1. `A` stays 0 through the bounce and rises exactly 4 cycles after `s2` settles. Exactly one `A_RISE` pulse occurs.
- Short glitch: `SW_B` high for 3 cycles then low. `B` stays 0 and `B_RISE`/`B_FALL` stay 0.
- Channel independence: `SW_A` and `SW_B` change on the same edge, in opposite directions (A 0→1, B 1→0 after B has settled high). `A_RISE` and `B_FALL` pulse in the same cycle, with no crosstalk.
- Reset mid-operation: `SW_A`=1 for 3 cycles, then `rst` pulses, then `SW_A` stays 1. The count restarts from 0, and `A` rises only 6 edges after `rst` falls.
